fp_add_norm_round: RTL

//  Post-add normalise/round/pack stage for the single-precision adder; sits directly downstream of the

---
 rtl/fp_add_norm_round.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fp_add_norm_round.sv
// fp_add_norm_round
//   Post-add normalise / round / pack stage of the single-precision adder.
//   It takes the raw sum from the mantissa add/subtract stage and produces a
//   packed IEEE-754 word. Normalisation moves one bit per cycle. Rounding is
//   round-to-nearest-even.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   upstream raw sum valid
//   in_ready   stage can accept (high only while idle)
//   in_sign    sign of the raw sum
//   in_exp     biased exponent of the larger operand
//   in_mant    [MW-1]=carry [MW-2]=hidden [MW-3:3]=fraction [2]=G [1]=R [0]=S
//   out_valid  result valid; held until out_ready
//   out_ready  downstream accepts the result
//   sum        packed result {sign, exponent, fraction}
//   out_flags  {overflow, underflow, inexact, zero}
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a raw sum; in_ready high
// NORM   | carry fix-up, zero detect, or one left shift per cycle
// ROUND  | round to nearest-even, detect overflow, and pack the result
// DONE   | result presented; wait for out_ready

module fp_add_norm_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [FRAC_W+4:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   sum,
    output logic [3:0]              out_flags
);

    localparam int MW = FRAC_W + 5;
    localparam int EW = EXP_W + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EW-1:0]    E_ONE    = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]    E_MAX    = {2'b00, EXP_ONES};

    logic [1:0]    state;
    logic          sign_q;
    logic [EW-1:0] e_q;
    logic [MW-1:0] m_q;

    // Rounding datapath, used only in ROUND.
    logic                lsb_b, g_b, r_b, s_b;
    logic                inexact, round_up;
    logic [FRAC_W+1:0]   rnd;
    logic                rnd_h;
    logic [FRAC_W-1:0]   rnd_f;
    logic [EW-1:0]       e_rnd;
    logic                ovf;
    logic [EXP_W-1:0]    exp_pk;

    always_comb begin
        lsb_b    = m_q[3];
        g_b      = m_q[2];
        r_b      = m_q[1];
        s_b      = m_q[0];
        inexact  = g_b | r_b | s_b;
        round_up = g_b & (r_b | s_b | lsb_b);
        rnd      = {1'b0, m_q[MW-2:3]} + {{(FRAC_W+1){1'b0}}, round_up};
        rnd_h    = rnd[FRAC_W];
        rnd_f    = rnd[FRAC_W-1:0];
        e_rnd    = e_q;
        if (rnd[FRAC_W+1]) begin
            // Mantissa rounded past 2.0. After the shift right, the fraction is
            // all zeros, so the dropped bit is always 0.
            rnd_h = 1'b1;
            rnd_f = rnd[FRAC_W:1];
            e_rnd = e_q + E_ONE;
        end
        ovf = (e_rnd >= E_MAX);
        // A subnormal that rounds up into the hidden bit gets e (which is 1).
        // Otherwise the exponent field is 0.
        exp_pk = rnd_h ? e_rnd[EXP_W-1:0] : '0;
    end

    assign in_ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            sum       <= '0;
            out_flags <= '0;
            sign_q    <= 1'b0;
            e_q       <= '0;
            m_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_sign;
                        e_q    <= {2'b00, in_exp};
                        m_q    <= in_mant;
                        if (in_exp == EXP_ONES) begin
                            // Inf/NaN passes straight through with its payload.
                            sum       <= {in_sign, EXP_ONES, in_mant[FRAC_W+2:3]};
                            out_flags <= 4'b0000;
                            state     <= S_DONE;
                        end else begin
                            state <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    if (m_q[MW-1]) begin
                        // Carry out of the add. Fold the dropped bit into sticky.
                        m_q   <= {1'b0, m_q[MW-1:2], m_q[1] | m_q[0]};
                        e_q   <= e_q + E_ONE;
                        state <= S_ROUND;
                    end else if (m_q == '0) begin
                        sum       <= '0;
                        out_flags <= 4'b0001;
                        state     <= S_DONE;
                    end else if (m_q[MW-2]) begin
                        state <= S_ROUND;
                    end else if (e_q <= E_ONE) begin
                        // Exponent floor reached: the result stays subnormal.
                        e_q   <= E_ONE;
                        state <= S_ROUND;
                    end else begin
                        m_q <= {m_q[MW-2:0], 1'b0};
                        e_q <= e_q - E_ONE;
                    end
                end
                S_ROUND: begin
                    if (ovf) begin
                        sum       <= {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
                        out_flags <= 4'b1010;
                    end else begin
                        sum       <= {sign_q, exp_pk, rnd_f};
                        out_flags <= {1'b0, ~rnd_h & inexact, inexact, 1'b0};
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
